// File: rtl/hit_pkg.sv
// rtl/hit_pkg.sv - shared types and helpers for the hit-point/normal join
package hit_pkg;

  localparam int SIZE = 64;

  typedef logic [2:0][SIZE-1:0] vec3_t;

  typedef struct packed {
    vec3_t normal;
    vec3_t point;
    logic  invalid;
  } hit_rec_t;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == DROP_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead FIFO with extra-bit binary pointers for full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/hit_join.sv
// rtl/hit_join.sv - pairs hit-point and normal streams into shading records
// and tracks issue credits so the upstream issuer never overruns the join FIFOs.
module hit_join #(
  parameter int SIZE         = 64,
  parameter int DEPTH        = 8,
  parameter int MAX_INFLIGHT = 8,
  parameter int DROP_INVALID = 0
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               issue_fire,
  output logic                               issue_ok,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight,
  input  logic [2:0][SIZE-1:0]               hp_axis_tdata,
  input  logic                               hp_axis_invalid,
  input  logic                               hp_axis_tvalid,
  output logic                               hp_axis_tready,
  input  logic [2:0][SIZE-1:0]               nrm_axis_tdata,
  input  logic                               nrm_axis_tvalid,
  output logic                               nrm_axis_tready,
  output logic [5:0][SIZE-1:0]               hit_axis_tdata,
  output logic                               hit_axis_tinvalid,
  output logic                               hit_axis_tvalid,
  input  logic                               hit_axis_tready,
  output logic [15:0]                        drop_count,
  output logic                               overflow_err
);

  import hit_pkg::*;

  localparam int PW = 3*SIZE + 1;
  localparam int NW = 3*SIZE;
  localparam int IW = $clog2(MAX_INFLIGHT+1);
  localparam logic [IW-1:0] INF_MAX = IW'(MAX_INFLIGHT);
  localparam logic [IW-1:0] INF_ONE = IW'(1);

  logic          p_full, p_empty, n_full, n_empty;
  logic [PW-1:0] p_head;
  logic [NW-1:0] n_head;
  logic          head_invalid, pair_avail, can_load;
  logic          drop, emit, pop, fire_ok, dec;

  logic [5:0][SIZE-1:0] data_q, data_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tinvalid_q, tinvalid_d;
  logic [IW-1:0]        inflight_q, inflight_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 ovf_q, ovf_d;

  sync_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_p_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (hp_axis_tvalid),
    .wr_data ({hp_axis_invalid, hp_axis_tdata}),
    .full    (p_full),
    .rd_en   (pop),
    .rd_data (p_head),
    .empty   (p_empty)
  );

  sync_fifo #(.WIDTH(NW), .DEPTH(DEPTH)) u_n_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (nrm_axis_tvalid),
    .wr_data (nrm_axis_tdata),
    .full    (n_full),
    .rd_en   (pop),
    .rd_data (n_head),
    .empty   (n_empty)
  );

  assign hp_axis_tready  = !p_full;
  assign nrm_axis_tready = !n_full;
  assign issue_ok        = (inflight_q < INF_MAX);

  always_comb begin
    head_invalid = p_head[PW-1];
    pair_avail   = !p_empty && !n_empty;
    can_load     = !tvalid_q || hit_axis_tready;
    // Dropping does not need the output register, so it proceeds under stall.
    drop         = (DROP_INVALID != 0) && pair_avail && head_invalid;
    emit         = pair_avail && !drop && can_load;
    pop          = emit || drop;
    fire_ok      = issue_fire && issue_ok;
    dec          = pop && (inflight_q != '0);

    data_d     = data_q;
    tinvalid_d = tinvalid_q;
    tvalid_d   = tvalid_q;
    if (emit) begin
      data_d     = {n_head, p_head[PW-2:0]};
      tinvalid_d = head_invalid;
      tvalid_d   = 1'b1;
    end else if (hit_axis_tready) begin
      tvalid_d = 1'b0;
    end

    case ({fire_ok, dec})
      2'b10:   inflight_d = inflight_q + INF_ONE;
      2'b01:   inflight_d = inflight_q - INF_ONE;
      default: inflight_d = inflight_q;
    endcase

    ovf_d      = ovf_q || (issue_fire && !issue_ok) || (pop && (inflight_q == '0));
    drop_cnt_d = drop ? sat_inc16(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_q     <= '0;
      tvalid_q   <= 1'b0;
      tinvalid_q <= 1'b0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      tvalid_q   <= tvalid_d;
      tinvalid_q <= tinvalid_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign hit_axis_tdata    = data_q;
  assign hit_axis_tvalid   = tvalid_q;
  assign hit_axis_tinvalid = tinvalid_q;
  assign inflight          = inflight_q;
  assign drop_count        = drop_cnt_q;
  assign overflow_err      = ovf_q;

endmodule

// File: tb/tb_hit_join.sv
// tb/tb_hit_join.sv - bench for hit_join with a queue-based reference model
`timescale 1ns/1ps
module tb_hit_join;
  import hit_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXI  = 8;
  localparam logic [63:0] F1 = 64'h3FF0000000000000;
  localparam logic [63:0] F2 = 64'h4000000000000000;
  localparam logic [63:0] F3 = 64'h4008000000000000;

  typedef struct packed {
    logic  inv;
    vec3_t pt;
  } pbeat_t;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic  sel, issue_fire, hp_inv, hp_valid, nrm_valid, out_ready;
  vec3_t hp_data, nrm_data;
  int    lit_id;
  int    cyc = 0;

  logic a_fire, a_hpv, a_nv, b_fire, b_hpv, b_nv;
  assign a_fire = issue_fire & ~sel;
  assign b_fire = issue_fire & sel;
  assign a_hpv  = hp_valid & ~sel;
  assign b_hpv  = hp_valid & sel;
  assign a_nv   = nrm_valid & ~sel;
  assign b_nv   = nrm_valid & sel;

  logic              a_ok, a_hpr, a_nr, a_tinv, a_tv, a_ovf;
  logic              b_ok, b_hpr, b_nr, b_tinv, b_tv, b_ovf;
  logic [3:0]        a_inf, b_inf;
  logic [15:0]       a_dc, b_dc;
  logic [5:0][63:0]  a_data, b_data;

  hit_join #(.SIZE(64), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .DROP_INVALID(0)) u_dut_a (
    .aclk(aclk), .aresetn(aresetn), .issue_fire(a_fire), .issue_ok(a_ok), .inflight(a_inf),
    .hp_axis_tdata(hp_data), .hp_axis_invalid(hp_inv), .hp_axis_tvalid(a_hpv), .hp_axis_tready(a_hpr),
    .nrm_axis_tdata(nrm_data), .nrm_axis_tvalid(a_nv), .nrm_axis_tready(a_nr),
    .hit_axis_tdata(a_data), .hit_axis_tinvalid(a_tinv), .hit_axis_tvalid(a_tv),
    .hit_axis_tready(out_ready), .drop_count(a_dc), .overflow_err(a_ovf)
  );

  hit_join #(.SIZE(64), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .DROP_INVALID(1)) u_dut_b (
    .aclk(aclk), .aresetn(aresetn), .issue_fire(b_fire), .issue_ok(b_ok), .inflight(b_inf),
    .hp_axis_tdata(hp_data), .hp_axis_invalid(hp_inv), .hp_axis_tvalid(b_hpv), .hp_axis_tready(b_hpr),
    .nrm_axis_tdata(nrm_data), .nrm_axis_tvalid(b_nv), .nrm_axis_tready(b_nr),
    .hit_axis_tdata(b_data), .hit_axis_tinvalid(b_tinv), .hit_axis_tvalid(b_tv),
    .hit_axis_tready(out_ready), .drop_count(b_dc), .overflow_err(b_ovf)
  );

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference state: DUT A tracked cycle by cycle, DUT B at transaction level.
  pbeat_t           mp[$];
  vec3_t            mn[$];
  logic [5:0][63:0] m_data = '0;
  logic             m_ov = 1'b0, m_inv = 1'b0, m_ovf = 1'b0;
  int               m_inf = 0;
  int               a_recs = 0;
  int               first_valid_cyc = -1;
  pbeat_t           bp[$];
  vec3_t            bn[$];
  logic [383:0]     b_exp[$];
  logic [383:0]     b_got[2];
  int               b_recs = 0;

  always @(negedge aclk) begin
    logic   m_hpr, m_nr, m_pop, m_fire_ok, m_dec;
    pbeat_t pb;
    vec3_t  nb;
    if (!aresetn) begin
      check("rst_tvalid", 384'(a_tv), 384'(0));
      check("rst_tdata", a_data, 384'(0));
      check("rst_tinvalid", 384'(a_tinv), 384'(0));
      check("rst_inflight", 384'(a_inf), 384'(0));
      check("rst_drop_count", 384'(b_dc), 384'(0));
      check("rst_overflow", 384'(a_ovf), 384'(0));
      check("rst_issue_ok", 384'(a_ok), 384'(1));
      check("rst_b_tvalid", 384'(b_tv), 384'(0));
      mp.delete(); mn.delete(); bp.delete(); bn.delete(); b_exp.delete();
      m_data = '0; m_ov = 1'b0; m_inv = 1'b0; m_ovf = 1'b0; m_inf = 0;
      first_valid_cyc = -1;
    end else begin
      m_hpr = (mp.size() < DEPTH);
      m_nr  = (mn.size() < DEPTH);
      check("a_tvalid", 384'(a_tv), 384'(m_ov));
      check("a_tdata", a_data, m_data);
      check("a_tinvalid", 384'(a_tinv), 384'(m_inv));
      check("a_inflight", 384'(a_inf), 384'(m_inf));
      check("a_issue_ok", 384'(a_ok), 384'(m_inf < MAXI));
      check("a_overflow", 384'(a_ovf), 384'(m_ovf));
      check("a_hp_tready", 384'(a_hpr), 384'(m_hpr));
      check("a_nrm_tready", 384'(a_nr), 384'(m_nr));
      if (a_tv && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (a_tv && out_ready) a_recs++;

      m_pop     = (mp.size() > 0) && (mn.size() > 0) && (!m_ov || out_ready);
      m_fire_ok = a_fire && (m_inf < MAXI);
      m_dec     = m_pop && (m_inf > 0);
      if (a_fire && !(m_inf < MAXI)) m_ovf = 1'b1;
      if (m_pop && m_inf == 0) m_ovf = 1'b1;
      m_inf = m_inf + (m_fire_ok ? 1 : 0) - (m_dec ? 1 : 0);
      if (m_pop) begin
        pb = mp.pop_front();
        nb = mn.pop_front();
        m_data = {nb, pb.pt};
        m_inv  = pb.inv;
        m_ov   = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (a_hpv && m_hpr) mp.push_back({hp_inv, hp_data});
      if (a_nv && m_nr) mn.push_back(nrm_data);

      if (b_tv && out_ready) begin
        if (b_exp.size() == 0) check("b_extra_record", 384'(b_tv), 384'(0));
        else check("b_record", b_data, b_exp.pop_front());
        if (b_recs < 2) b_got[b_recs] = b_data;
        b_recs++;
      end
      if (b_hpv && b_hpr) bp.push_back({hp_inv, hp_data});
      if (b_nv && b_nr) bn.push_back(nrm_data);
      while (bp.size() > 0 && bn.size() > 0) begin
        pb = bp.pop_front();
        nb = bn.pop_front();
        if (!pb.inv) b_exp.push_back({nb, pb.pt});
      end
    end

    case (lit_id)
      1: check("t1_inflight_before_pop", 384'(a_inf), 384'(1));
      2: begin
        check("t1_tvalid", 384'(a_tv), 384'(1));
        check("t1_tdata", a_data, {64'd0, 64'd0, F1, F3, F2, F1});
        check("t1_inflight_after_pop", 384'(a_inf), 384'(0));
        check("t1_latency_cycle", 384'(first_valid_cyc), 384'(11));
      end
      3: begin
        check("t2_inflight", 384'(a_inf), 384'(8));
        check("t2_issue_ok", 384'(a_ok), 384'(0));
        check("t2_overflow", 384'(a_ovf), 384'(1));
      end
      4: check("t4_hp_full_tready", 384'(a_hpr), 384'(0));
      5: begin
        check("t4_hold_tvalid", 384'(a_tv), 384'(1));
        check("t4_hold_tdata", a_data, {64'd600, 64'd500, 64'd400, 64'd300, 64'd200, 64'd100});
      end
      6: begin
        check("t4_record_count", 384'(a_recs), 384'(9));
        check("t4_inflight", 384'(a_inf), 384'(0));
      end
      11: begin
        check("t3_stalled_drop_count", 384'(b_dc), 384'(2));
        check("t3_stalled_tvalid", 384'(b_tv), 384'(1));
      end
      7: begin
        check("t3_drop_count", 384'(b_dc), 384'(2));
        check("t3_inflight", 384'(b_inf), 384'(0));
        check("t3_record_count", 384'(b_recs), 384'(2));
        check("t3_rec0", b_got[0], {64'd60, 64'd50, 64'd40, 64'd30, 64'd20, 64'd10});
        check("t3_rec1", b_got[1], {64'd63, 64'd53, 64'd43, 64'd33, 64'd23, 64'd13});
        check("t3_overflow", 384'(b_ovf), 384'(0));
      end
      8: begin
        check("t5_queued_tvalid", 384'(a_tv), 384'(1));
        check("t5_queued_inflight", 384'(a_inf), 384'(2));
      end
      9: begin
        check("t5_rst_tvalid", 384'(a_tv), 384'(0));
        check("t5_rst_overflow", 384'(a_ovf), 384'(0));
      end
      10: begin
        check("t5_no_stale_records", 384'(a_recs), 384'(9));
        check("t5_tvalid_idle", 384'(a_tv), 384'(0));
        check("t5_inflight", 384'(a_inf), 384'(0));
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic lit(input int id);
    lit_id = id;
    tick();
    lit_id = 0;
  endtask

  initial begin
    aresetn = 1'b0; sel = 1'b0; issue_fire = 1'b0; hp_inv = 1'b0; hp_valid = 1'b0;
    nrm_valid = 1'b0; out_ready = 1'b1; hp_data = '0; nrm_data = '0; lit_id = 0;
    repeat (3) tick();
    aresetn = 1'b1;

    // single transaction, hp in cycle 5, nrm in cycle 9
    tick();
    issue_fire = 1'b1; tick(); issue_fire = 1'b0;
    wait_cyc(5);
    hp_valid = 1'b1; hp_data = {F3, F2, F1}; tick(); hp_valid = 1'b0;
    wait_cyc(9);
    nrm_valid = 1'b1; nrm_data = {64'd0, 64'd0, F1}; tick(); nrm_valid = 1'b0;
    lit(1);
    lit(2);

    // credit exhaustion
    issue_fire = 1'b1;
    repeat (9) tick();
    issue_fire = 1'b0;
    lit(3);

    // lone hp channel fills, output stalled, then drain
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      hp_valid = 1'b1; hp_inv = (k == 2);
      hp_data = {64'(k + 300), 64'(k + 200), 64'(k + 100)};
      tick();
    end
    hp_valid = 1'b0; hp_inv = 1'b0;
    lit(4);
    hp_valid = 1'b1; hp_data = {64'd999, 64'd999, 64'd999}; tick(); hp_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      nrm_valid = 1'b1;
      nrm_data = {64'(k + 600), 64'(k + 500), 64'(k + 400)};
      tick();
    end
    nrm_valid = 1'b0;
    repeat (3) tick();
    lit(5);
    out_ready = 1'b1;
    repeat (10) tick();
    lit(6);

    // drop-invalid instance, flags 0,1,1,0, drops under output stall
    sel = 1'b1; out_ready = 1'b0;
    issue_fire = 1'b1; repeat (4) tick(); issue_fire = 1'b0;
    for (int k = 0; k < 4; k++) begin
      hp_valid = 1'b1; hp_inv = (k == 1) || (k == 2);
      hp_data = {64'(k + 30), 64'(k + 20), 64'(k + 10)};
      tick();
    end
    hp_valid = 1'b0; hp_inv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nrm_valid = 1'b1;
      nrm_data = {64'(k + 60), 64'(k + 50), 64'(k + 40)};
      tick();
    end
    nrm_valid = 1'b0;
    repeat (3) tick();
    lit(11);
    out_ready = 1'b1;
    repeat (5) tick();
    lit(7);

    // reset with records queued
    sel = 1'b0; out_ready = 1'b0;
    issue_fire = 1'b1; repeat (3) tick(); issue_fire = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hp_valid = 1'b1; nrm_valid = 1'b1;
      hp_data = {64'(k + 73), 64'(k + 72), 64'(k + 71)};
      nrm_data = {64'(k + 83), 64'(k + 82), 64'(k + 81)};
      tick();
    end
    hp_valid = 1'b0; nrm_valid = 1'b0;
    repeat (3) tick();
    lit(8);
    aresetn = 1'b0;
    lit(9);
    aresetn = 1'b1; out_ready = 1'b1;
    repeat (6) tick();
    lit(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
